// File: rtl/br_redirect_ctl_pkg.sv
// Shared types for the redirect controller: physical address, FSM state and request source.
package br_redirect_ctl_pkg;

    localparam int PADDR_W = 32;

    typedef logic [PADDR_W-1:0] t_paddr;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FLUSH,
        RD_DRAIN,
        RD_REDIR
    } t_redir_state;

    typedef enum logic {
        RDS_BR,
        RDS_TRAP
    } t_redir_src;

endpackage

// File: rtl/br_redirect_ctl_sat_cnt.sv
// Saturating event counter: increments on inc and holds once it reaches all-ones.
module sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/br_redirect_ctl.sv
// Redirect sequencer: arbitrates trap vs. mispredict, flushes, waits for the pipe
// to drain, then presents the corrected target to fetch over valid/ready.
module br_redirect_ctl
    import br_redirect_ctl_pkg::*;
#(
    parameter int FLUSH_MIN_CYC = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_resvld_ex0,
    input  logic             br_mispred_ex0,
    input  t_paddr           br_tgt_ex0,
    input  logic             trap_req,
    input  t_paddr           trap_tgt,
    output logic             trap_ack,
    input  logic             pipe_empty,
    output logic             flush,
    output logic             stall_issue,
    output logic             fe_redir_valid,
    output t_paddr           fe_redir_tgt,
    input  logic             fe_redir_ready,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] trap_cnt
);

    // FLUSH exits once the incremented count reaches this value
    localparam logic [4:0] FLUSH_LAST = 5'(FLUSH_MIN_CYC - 1);

    t_redir_state state, state_d;
    logic [3:0]   fcnt, fcnt_d;
    t_paddr       tgt_q;
    logic         valid_q;
    logic         br_req, idle, accept, acc_trap, acc_br;
    logic [4:0]   fcnt_inc;

    assign br_req   = br_resvld_ex0 & br_mispred_ex0;
    assign idle     = (state == RD_IDLE);
    assign accept   = idle & (trap_req | br_req);
    assign acc_trap = idle & trap_req;
    assign acc_br   = idle & br_req & ~trap_req;
    assign fcnt_inc = {1'b0, fcnt} + 5'd1;

    assign trap_ack       = acc_trap;
    assign flush          = accept;
    assign stall_issue    = ~idle;
    assign fe_redir_valid = valid_q;
    assign fe_redir_tgt   = tgt_q;

    always_comb begin
        state_d = state;
        fcnt_d  = fcnt;
        unique case (state)
            RD_IDLE: begin
                fcnt_d = '0;
                if (accept)
                    state_d = RD_FLUSH;
            end
            RD_FLUSH: begin
                fcnt_d = fcnt_inc[3:0];
                if (fcnt_inc >= FLUSH_LAST)
                    state_d = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (pipe_empty)
                    state_d = RD_REDIR;
            end
            RD_REDIR: begin
                if (fe_redir_ready)
                    state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RD_IDLE;
            fcnt    <= '0;
            valid_q <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state   <= state_d;
            fcnt    <= fcnt_d;
            valid_q <= (state_d == RD_REDIR);
            if (accept)
                tgt_q <= trap_req ? trap_tgt : br_tgt_ex0;
        end
    end

    sat_cnt #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (acc_br),
        .cnt   (mispred_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_trap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (acc_trap),
        .cnt   (trap_cnt)
    );

`ifndef SYNTHESIS
    t_redir_src src_dbg;
    logic       hold_q, flush_q;
    t_paddr     hold_tgt_q;

    assign src_dbg = trap_req ? RDS_TRAP : RDS_BR;

    always_ff @(posedge clk) begin
        if (!reset && accept)
            $display("INFO br_redirect_ctl: accept %s tgt=%h", src_dbg.name(),
                     trap_req ? trap_tgt : br_tgt_ex0);
        if (!reset && fe_redir_valid && fe_redir_ready)
            $display("INFO br_redirect_ctl: redirect tgt=%h", fe_redir_tgt);

        if (!reset && hold_q)
            assert (fe_redir_tgt == hold_tgt_q)
                else $error("br_redirect_ctl: fe_redir_tgt changed while stalled");
        assert (!(flush && flush_q))
            else $error("br_redirect_ctl: flush held longer than one cycle");
        assert (!trap_ack || trap_req)
            else $error("br_redirect_ctl: trap_ack without trap_req");

        hold_q     <= !reset && fe_redir_valid && !fe_redir_ready;
        hold_tgt_q <= fe_redir_tgt;
        flush_q    <= !reset && flush;
    end
`endif

endmodule

// File: tb/tb_br_redirect_ctl.sv
// Directed plus randomized bench for br_redirect_ctl against a transaction-level model.
module tb_br_redirect_ctl;
    import br_redirect_ctl_pkg::*;

    localparam int FMC     = 2;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    // first cycle (relative to accept) in which pipe_empty can release the drain
    localparam int DRAIN_OFS = 1 + ((FMC - 1) > 1 ? (FMC - 1) : 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          br_resvld_ex0 = 1'b0, br_mispred_ex0 = 1'b0;
    t_paddr        br_tgt_ex0 = '0, trap_tgt = '0;
    logic          trap_req = 1'b0, pipe_empty = 1'b1, fe_redir_ready = 1'b1;
    logic          trap_ack, flush, stall_issue, fe_redir_valid;
    t_paddr        fe_redir_tgt;
    logic [CW-1:0] mispred_cnt, trap_cnt;

    always #5 clk = ~clk;

    br_redirect_ctl #(.FLUSH_MIN_CYC(FMC), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .br_resvld_ex0  (br_resvld_ex0),
        .br_mispred_ex0 (br_mispred_ex0),
        .br_tgt_ex0     (br_tgt_ex0),
        .trap_req       (trap_req),
        .trap_tgt       (trap_tgt),
        .trap_ack       (trap_ack),
        .pipe_empty     (pipe_empty),
        .flush          (flush),
        .stall_issue    (stall_issue),
        .fe_redir_valid (fe_redir_valid),
        .fe_redir_tgt   (fe_redir_tgt),
        .fe_redir_ready (fe_redir_ready),
        .mispred_cnt    (mispred_cnt),
        .trap_cnt       (trap_cnt)
    );

    // model: one outstanding redirect transaction at a time
    bit     m_busy, m_redir, last_ack;
    t_paddr m_tgt;
    int     m_mc, m_tc, m_cyc, m_release;
    int     nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge after inputs are set; checks this cycle, then advances one clock
    task automatic tick();
        bit breq, e_flush, e_ack;
        #1;
        breq    = br_resvld_ex0 && br_mispred_ex0;
        e_flush = !m_busy && (trap_req || breq);
        e_ack   = !m_busy && trap_req;
        chk("flush", flush, e_flush);
        chk("trap_ack", trap_ack, e_ack);
        chk("stall_issue", stall_issue, m_busy);
        chk("fe_redir_valid", fe_redir_valid, m_redir);
        chk("fe_redir_tgt", fe_redir_tgt, m_tgt);
        chk("mispred_cnt", mispred_cnt, m_mc);
        chk("trap_cnt", trap_cnt, m_tc);
        last_ack = e_ack;
        if (reset) begin
            m_busy = 0; m_redir = 0; m_tgt = '0; m_mc = 0; m_tc = 0;
        end else if (e_flush) begin
            m_busy    = 1;
            m_tgt     = trap_req ? trap_tgt : br_tgt_ex0;
            m_release = m_cyc + DRAIN_OFS;
            if (trap_req) m_tc = (m_tc == CNT_MAX) ? CNT_MAX : m_tc + 1;
            else          m_mc = (m_mc == CNT_MAX) ? CNT_MAX : m_mc + 1;
        end else if (m_busy && !m_redir && m_cyc >= m_release && pipe_empty) begin
            m_redir = 1;
        end else if (m_redir && fe_redir_ready) begin
            m_redir = 0; m_busy = 0;
        end
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic run_idle();
        int n = 0;
        while (m_busy && n < 200) begin tick(); n++; end
        chk("idle_timeout", m_busy, 0);
    endtask

    task automatic br_pulse(input t_paddr t);
        br_resvld_ex0 = 1; br_mispred_ex0 = 1; br_tgt_ex0 = t;
        tick();
        br_resvld_ex0 = 0; br_mispred_ex0 = 0;
    endtask

    initial begin
        int lat, mc0;
        repeat (2) @(negedge clk);
        reset = 0;
        m_busy = 0; m_redir = 0; m_tgt = '0; m_mc = 0; m_tc = 0; m_cyc = 0;

        // reset state
        tick(); tick();

        // plain mispredict, latency to valid
        br_pulse(32'h1000_0040);
        lat = 1;
        while (!fe_redir_valid && lat < 20) begin tick(); lat++; end
        chk("redir_latency", lat, FMC + 1);
        chk("redir_tgt", fe_redir_tgt, 32'h1000_0040);
        run_idle();
        chk("mispred_one", mispred_cnt, 1);

        // trap and branch together: trap wins
        trap_req = 1; trap_tgt = 32'h8000_0000;
        br_resvld_ex0 = 1; br_mispred_ex0 = 1; br_tgt_ex0 = 32'h1234_5678;
        tick();
        trap_req = 0; br_resvld_ex0 = 0; br_mispred_ex0 = 0;
        run_idle();
        chk("trap_tgt_sel", fe_redir_tgt, 32'h8000_0000);
        chk("trap_one", trap_cnt, 1);
        chk("mispred_unchanged", mispred_cnt, 1);

        // long drain
        pipe_empty = 0;
        br_pulse(32'h0000_2000);
        repeat (10) tick();
        chk("drain_stall", stall_issue, 1);
        pipe_empty = 1;
        run_idle();

        // fetch back-pressure
        fe_redir_ready = 0;
        br_pulse(32'h0000_3000);
        repeat (8) tick();
        chk("bp_valid_held", fe_redir_valid, 1);
        fe_redir_ready = 1;
        run_idle();

        // br every cycle while busy; trap raised during drain, branch back-to-back
        mc0 = m_mc;
        pipe_empty = 0;
        br_resvld_ex0 = 1; br_mispred_ex0 = 1; br_tgt_ex0 = 32'h0000_4000;
        repeat (5) tick();
        trap_req = 1; trap_tgt = 32'h8000_0100;
        repeat (3) tick();
        pipe_empty = 1;
        while (!last_ack && m_cyc < 5000) tick();
        chk("trap_after_drain", last_ack, 1);
        chk("wrong_path_dropped", mispred_cnt, mc0 + 1);
        trap_req = 0;
        br_resvld_ex0 = 0; br_mispred_ex0 = 0;
        run_idle();

        // reset while in REDIR
        fe_redir_ready = 0;
        br_pulse(32'h0000_5000);
        repeat (4) tick();
        reset = 1;
        tick();
        reset = 0;
        fe_redir_ready = 1;
        tick();
        chk("post_reset_cnt", mispred_cnt, 0);

        // saturation
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            br_pulse(32'h0000_6000 + 32'(i));
            run_idle();
        end
        chk("mispred_sat", mispred_cnt, CNT_MAX);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            br_resvld_ex0  = ($urandom_range(0, 3) == 0);
            br_mispred_ex0 = $urandom_range(0, 1);
            br_tgt_ex0     = $urandom;
            if (!trap_req && $urandom_range(0, 15) == 0) begin
                trap_req = 1; trap_tgt = $urandom;
            end
            pipe_empty     = ($urandom_range(0, 9) < 7);
            fe_redir_ready = ($urandom_range(0, 9) < 6);
            tick();
            if (last_ack) trap_req = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/br_redirect_ctl.md
Name: br_redirect_ctl

Overview:
Redirect controller that sequences pipeline recovery after a control-flow change.
- Requesters: branch results from the EX branch unit (mispredict, true target) and a trap/exception redirect source.
- Arbitrates between the two requesters.
- Flushes the pipeline, stalls issue until the machine drains, then hands the corrected fetch target to the front end over a valid/ready handshake.
- Sits between EX/retire and the fetch PC logic.

Parameters:
FLUSH_MIN_CYC, 2, minimum cycles spent in FLUSH before DRAIN may complete (1..15)
CNT_W, 32, width of the mispredict and trap event counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
br_resvld_ex0  input  1  branch result valid this cycle
br_mispred_ex0  input  1  branch mispredicted (qualified by br_resvld_ex0)
br_tgt_ex0  input  t_paddr  true branch target
trap_req  input  1  trap redirect request; held until trap_ack
trap_tgt  input  t_paddr  trap handler target; stable while trap_req
trap_ack  output  1  one-cycle accept of trap_req
pipe_empty  input  1  all in-flight uops drained
flush  output  1  one-cycle pipeline flush pulse
stall_issue  output  1  block issue/decode
fe_redir_valid  output  1  redirect to fetch valid
fe_redir_tgt  output  t_paddr  redirect target
fe_redir_ready  input  1  fetch accepts redirect
mispred_cnt  output  CNT_W  accepted-mispredict counter, saturating
trap_cnt  output  CNT_W  accepted-trap counter, saturating

Behaviour:
- Reset values:
  - state=IDLE.
  - All 1-bit outputs 0.
  - fe_redir_tgt=0.
  - Counters 0.
  - Flush-cycle counter 0.
- Branch request (br_req) = br_resvld_ex0 & br_mispred_ex0.
  - Fire-and-forget; there is no back-pressure.
  - br_req outside IDLE is dropped and not counted (it is wrong-path).
- Arbitration in IDLE: trap_req has priority over br_req.
  - Simultaneous requests: trap accepted; branch dropped and not counted.
- Accept in IDLE:
  - Latch target (trap_tgt or br_tgt_ex0) into tgt_q.
  - trap_ack=1 in the same cycle when the trap wins.
  - flush=1 in the same cycle, combinational from accept.
  - Increment the corresponding counter (holds at all-ones).
  - Next state FLUSH; flush counter cleared.
- FLUSH:
  - stall_issue=1; counter increments each cycle.
  - When count reaches FLUSH_MIN_CYC-1, go to DRAIN.
- DRAIN:
  - stall_issue=1.
  - When pipe_empty=1, go to REDIR; fe_redir_valid rises the next cycle.
- REDIR:
  - stall_issue=1; fe_redir_valid=1; fe_redir_tgt=tgt_q.
  - Target stays stable while valid & !ready.
  - On fe_redir_valid & fe_redir_ready, go to IDLE next cycle; stall_issue drops in that IDLE cycle.
- trap_req outside IDLE: no ack; the request stays pending and is taken on return to IDLE (the requester holds it).
- stall_issue = (state != IDLE).
- fe_redir_valid is registered, from state==REDIR.
- Minimum latency from accept to fe_redir_valid: FLUSH_MIN_CYC + 1 cycles (pipe_empty already high).
- Back-to-back: a request in the IDLE cycle immediately after REDIR completes is accepted normally.
- reset mid-operation: next cycle state=IDLE and all outputs at reset values; the pending target is discarded.
- t_paddr arithmetic: none; targets are passed unmodified.

Decomposition:
- Package common: t_paddr (existing).
- New typedef in common: t_redir_state enum {RD_IDLE, RD_FLUSH, RD_DRAIN, RD_REDIR}.
- New typedef in common: t_redir_src enum {RDS_BR, RDS_TRAP}, used for debug prints.
- Sub-module sat_cnt (CNT_W, inc input, saturating), instantiated twice for the counters.
- SIMULATION-only INFO print on each accept and each redirect handshake.
- ASSERT checks:
  - fe_redir_tgt stable while valid & !ready.
  - flush is a single-cycle pulse.
  - trap_ack only when trap_req.

Test Plan:
- IDLE, br_req with tgt=0x1000_0040, pipe_empty=1, ready=1 → flush at cycle 0; valid at cycle 3 (FLUSH_MIN_CYC=2); tgt 0x1000_0040; IDLE at cycle 4; mispred_cnt=1.
- trap_req (tgt 0x8000_0000) and br_req together → trap_ack=1, redirect to 0x8000_0000, trap_cnt=1, mispred_cnt=0.
- pipe_empty held 0 for 10 cycles in DRAIN → stall_issue stays 1, no valid; pipe_empty=1 → valid the next cycle.
- ready held 0 for 5 cycles → valid and tgt stable; ready=1 → IDLE next cycle.
- br_req every cycle while busy → exactly one accept, mispred_cnt=1; trap_req raised in DRAIN → acked in the first IDLE cycle.
- reset asserted in REDIR → next cycle all outputs 0; counter forced to all-ones then one more accept → remains all-ones.
